// File: rtl/oe_noc_pkg.sv
// Shared definitions for the odd-even mesh route unit: port indices, VC state
// encoding and the minimal odd-even admissible-output function.
package oe_noc_pkg;

    localparam int P_E     = 0;
    localparam int P_W     = 1;
    localparam int P_N     = 2;
    localparam int P_S     = 3;
    localparam int P_L     = 4;
    localparam int NPORT   = 5;
    localparam int COORD_W = 4;

    localparam logic [NPORT-1:0] X_MASK = 5'b00011;
    localparam logic [NPORT-1:0] Y_MASK = 5'b01100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RC   = 2'd1,
        HOLD = 2'd2
    } vc_state_e;

    function automatic logic [NPORT-1:0] oe_admissible(
        input logic [COORD_W-1:0] cur_x,
        input logic [COORD_W-1:0] cur_y,
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [COORD_W-1:0] src_x
    );
        logic [NPORT-1:0] set_v;
        logic [NPORT-1:0] y_dir;
        set_v = '0;
        y_dir = '0;
        if (dst_y > cur_y) y_dir[P_N] = 1'b1;
        else               y_dir[P_S] = 1'b1;

        if (dst_x == cur_x) begin
            if (dst_y == cur_y) set_v[P_L] = 1'b1;
            else                set_v      = y_dir;
        end else if (dst_x > cur_x) begin
            if (dst_y == cur_y) begin
                set_v[P_E] = 1'b1;
            end else begin
                // Turning north/south out of an even column is only legal at the source column
                if (cur_x[0] || (cur_x == src_x)) set_v = set_v | y_dir;
                if (dst_x[0] || ((dst_x - cur_x) != COORD_W'(1))) set_v[P_E] = 1'b1;
            end
        end else begin
            set_v[P_W] = 1'b1;
            if (!cur_x[0] && (dst_y != cur_y)) set_v = set_v | y_dir;
        end
        return set_v;
    endfunction

endpackage

// File: rtl/oe_route_sel.sv
// Picks one output from an admissible set: a lone candidate is taken as is,
// an X/Y pair goes to the port with strictly more credits, ties favour X.
module oe_route_sel
    import oe_noc_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic [NPORT-1:0] cand_i,
    input  logic [4*CW-1:0]  credits_i,
    output logic [NPORT-1:0] port_o
);

    logic [CW-1:0] x_cr;
    logic [CW-1:0] y_cr;
    logic          has_x;
    logic          has_y;

    always_comb begin
        x_cr  = cand_i[P_E] ? credits_i[P_E*CW +: CW] : credits_i[P_W*CW +: CW];
        y_cr  = cand_i[P_N] ? credits_i[P_N*CW +: CW] : credits_i[P_S*CW +: CW];
        has_x = cand_i[P_E] | cand_i[P_W];
        has_y = cand_i[P_N] | cand_i[P_S];
        port_o = cand_i;
        if (has_x && has_y) begin
            if (y_cr > x_cr) port_o = cand_i & Y_MASK;
            else             port_o = cand_i & X_MASK;
        end
    end

endmodule

// File: rtl/oe_route_unit.sv
// Per-VC route computation for one mesh router input port: latch head
// destination, compute an odd-even route for one cycle, then hold it until release.
module oe_route_unit
    import oe_noc_pkg::*;
#(
    parameter  int MESH_X = 4,
    parameter  int MESH_Y = 4,
    parameter  int NVC    = 2,
    parameter  int CW     = 3,
    localparam int XW     = (MESH_X > 1) ? $clog2(MESH_X) : 1,
    localparam int YW     = (MESH_Y > 1) ? $clog2(MESH_Y) : 1,
    localparam int VW     = (NVC > 1) ? $clog2(NVC) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [XW-1:0]        cur_x,
    input  logic [YW-1:0]        cur_y,
    input  logic                 hd_valid,
    input  logic [VW-1:0]        hd_vc,
    input  logic [XW-1:0]        hd_dst_x,
    input  logic [YW-1:0]        hd_dst_y,
    input  logic [XW-1:0]        hd_src_x,
    input  logic                 rel_valid,
    input  logic [VW-1:0]        rel_vc,
    input  logic [4*CW-1:0]      credits,
    output logic [NVC-1:0]       route_valid,
    output logic [NPORT*NVC-1:0] route_port,
    output logic                 err_proto,
    output logic                 err_dest
);

    localparam logic [XW:0] MAX_X = (XW+1)'(MESH_X);
    localparam logic [YW:0] MAX_Y = (YW+1)'(MESH_Y);

    logic                      dst_ok;
    logic [NVC-1:0]            proto_err;
    logic [NVC-1:0]            vc_in_rc;
    logic [NVC-1:0][XW-1:0]    vc_dst_x;
    logic [NVC-1:0][YW-1:0]    vc_dst_y;
    logic [NVC-1:0][XW-1:0]    vc_src_x;
    logic [XW-1:0]             rc_dst_x;
    logic [YW-1:0]             rc_dst_y;
    logic [XW-1:0]             rc_src_x;
    logic [NPORT-1:0]          rc_cand;
    logic [NPORT-1:0]          rc_port;
    logic                      err_proto_q;
    logic                      err_dest_q;

    assign dst_ok = ({1'b0, hd_dst_x} < MAX_X) && ({1'b0, hd_dst_y} < MAX_Y);

    // Heads arrive one per cycle and RC lasts one cycle, so at most one VC is in RC
    always_comb begin
        rc_dst_x = '0;
        rc_dst_y = '0;
        rc_src_x = '0;
        for (int v = 0; v < NVC; v++) begin
            if (vc_in_rc[v]) begin
                rc_dst_x = vc_dst_x[v];
                rc_dst_y = vc_dst_y[v];
                rc_src_x = vc_src_x[v];
            end
        end
    end

    assign rc_cand = oe_admissible(COORD_W'(cur_x), COORD_W'(cur_y),
                                   COORD_W'(rc_dst_x), COORD_W'(rc_dst_y),
                                   COORD_W'(rc_src_x));

    oe_route_sel #(.CW(CW)) u_sel (
        .cand_i    (rc_cand),
        .credits_i (credits),
        .port_o    (rc_port)
    );

    for (genvar gi = 0; gi < NVC; gi++) begin : g_vc
        vc_state_e        state_q;
        logic [XW-1:0]    dst_x_q;
        logic [YW-1:0]    dst_y_q;
        logic [XW-1:0]    src_x_q;
        logic [NPORT-1:0] route_q;
        logic             hd_hit;
        logic             rel_hit;
        logic             can_take;
        logic             accept;

        assign hd_hit   = hd_valid && (hd_vc == VW'(gi));
        assign rel_hit  = rel_valid && (rel_vc == VW'(gi));
        // A HOLD VC released this cycle may take a new head without an IDLE bubble
        assign can_take = (state_q == IDLE) || ((state_q == HOLD) && rel_hit);
        assign accept   = hd_hit && dst_ok && can_take;

        assign proto_err[gi] = (hd_hit && !can_take) || (rel_hit && (state_q != HOLD));
        assign vc_in_rc[gi]  = (state_q == RC);
        assign vc_dst_x[gi]  = dst_x_q;
        assign vc_dst_y[gi]  = dst_y_q;
        assign vc_src_x[gi]  = src_x_q;

        assign route_valid[gi]              = (state_q == HOLD);
        assign route_port[gi*NPORT +: NPORT] = route_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                dst_x_q <= '0;
                dst_y_q <= '0;
                src_x_q <= '0;
                route_q <= '0;
            end else begin
                if (accept) begin
                    dst_x_q <= hd_dst_x;
                    dst_y_q <= hd_dst_y;
                    src_x_q <= hd_src_x;
                end
                case (state_q)
                    IDLE: if (accept) state_q <= RC;
                    RC: begin
                        state_q <= HOLD;
                        route_q <= rc_port;
                    end
                    HOLD: begin
                        if (rel_hit) begin
                            state_q <= accept ? RC : IDLE;
                            route_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        route_q <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_proto_q <= 1'b0;
            err_dest_q  <= 1'b0;
        end else begin
            err_proto_q <= |proto_err;
            err_dest_q  <= hd_valid && !dst_ok;
        end
    end

    assign err_proto = err_proto_q;
    assign err_dest  = err_dest_q;

endmodule

// File: tb/tb_oe_route_unit.sv
// Directed bench for oe_route_unit: table of single-VC route vectors plus
// hand-written sequences for errors, same-cycle release/head and async reset.
module tb_oe_route_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cur_x, cur_y;
    logic        hd_valid;
    logic        hd_vc;
    logic [1:0]  hd_dst_x, hd_dst_y, hd_src_x;
    logic        rel_valid;
    logic        rel_vc;
    logic [11:0] credits;
    logic [1:0]  route_valid;
    logic [9:0]  route_port;
    logic        err_proto, err_dest;
    // 3x3 instance: the only way a 2-bit coordinate can fall outside the mesh
    logic [1:0]  b_route_valid;
    logic [9:0]  b_route_port;
    logic        b_err_proto, b_err_dest;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oe_route_unit dut (
        .clk(clk), .reset_n(reset_n), .cur_x(cur_x), .cur_y(cur_y),
        .hd_valid(hd_valid), .hd_vc(hd_vc), .hd_dst_x(hd_dst_x), .hd_dst_y(hd_dst_y),
        .hd_src_x(hd_src_x), .rel_valid(rel_valid), .rel_vc(rel_vc), .credits(credits),
        .route_valid(route_valid), .route_port(route_port),
        .err_proto(err_proto), .err_dest(err_dest)
    );

    oe_route_unit #(.MESH_X(3), .MESH_Y(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .cur_x(cur_x), .cur_y(cur_y),
        .hd_valid(hd_valid), .hd_vc(hd_vc), .hd_dst_x(hd_dst_x), .hd_dst_y(hd_dst_y),
        .hd_src_x(hd_src_x), .rel_valid(rel_valid), .rel_vc(rel_vc), .credits(credits),
        .route_valid(b_route_valid), .route_port(b_route_port),
        .err_proto(b_err_proto), .err_dest(b_err_dest)
    );

    typedef struct {
        logic [1:0] cx, cy, dx, dy, sx;
        logic [2:0] ce, cw, cn, cs;
        logic [4:0] exp_port;
    } vec_t;

    vec_t vec [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic head(input logic vc, input logic [1:0] dx, input logic [1:0] dy,
                        input logic [1:0] sx);
        hd_valid = 1'b1; hd_vc = vc; hd_dst_x = dx; hd_dst_y = dy; hd_src_x = sx;
    endtask

    initial begin
        //          cx    cy    dx    dy    sx    E     W     N     S     expected
        vec[0]  = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 3'd3, 3'd3, 3'd3, 3'd3, 5'b10000};
        vec[1]  = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 3'd2, 3'd0, 3'd5, 3'd0, 5'b00100};
        vec[2]  = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 3'd5, 3'd0, 3'd5, 3'd0, 5'b00001};
        vec[3]  = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd0, 3'd0, 3'd0, 3'd7, 3'd0, 5'b00001};
        vec[4]  = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 3'd7, 3'd0, 3'd0, 3'd0, 5'b00100};
        vec[5]  = '{2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 3'd0, 3'd0, 3'd0, 3'd7, 5'b00010};
        vec[6]  = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 3'd0, 3'd1, 3'd0, 3'd4, 5'b01000};
        vec[7]  = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 3'd0, 3'd4, 3'd0, 3'd4, 5'b00010};
        vec[8]  = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 3'd1, 3'd1, 3'd1, 3'd1, 5'b01000};
        vec[9]  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd1, 3'd1, 3'd1, 3'd1, 5'b00100};
        vec[10] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 3'd0, 3'd0, 3'd7, 3'd7, 5'b00001};
        vec[11] = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd2, 3'd3, 3'd0, 3'd4, 3'd0, 5'b00100};
        vec[12] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 3'd0, 3'd0, 3'd7, 3'd0, 5'b00001};

        reset_n = 1'b0; cur_x = 2'd0; cur_y = 2'd0;
        hd_valid = 1'b0; hd_vc = 1'b0; hd_dst_x = 2'd0; hd_dst_y = 2'd0; hd_src_x = 2'd0;
        rel_valid = 1'b0; rel_vc = 1'b0; credits = '0;
        step(); step();
        chk("reset_valid", route_valid, 2'b00);
        chk("reset_port", route_port, 10'd0);
        chk("reset_err_proto", err_proto, 1'b0);
        chk("reset_err_dest", err_dest, 1'b0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            cur_x = vec[i].cx; cur_y = vec[i].cy;
            credits = {vec[i].cs, vec[i].cn, vec[i].cw, vec[i].ce};
            head(1'b0, vec[i].dx, vec[i].dy, vec[i].sx);
            step();
            hd_valid = 1'b0;
            chk($sformatf("v%0d_rc_not_valid", i), route_valid[0], 1'b0);
            step();
            chk($sformatf("v%0d_valid", i), route_valid[0], 1'b1);
            chk($sformatf("v%0d_port", i), route_port[4:0], vec[i].exp_port);
            $display("vec %0d cur=(%0d,%0d) dst=(%0d,%0d) port=%b", i, cur_x, cur_y,
                     vec[i].dx, vec[i].dy, route_port[4:0]);
            rel_valid = 1'b1; rel_vc = 1'b0;
            step();
            rel_valid = 1'b0;
            chk($sformatf("v%0d_released", i), route_valid[0], 1'b0);
            chk($sformatf("v%0d_port_cleared", i), route_port[4:0], 5'd0);
        end

        // VC1 holds E while VC0 is set up; release to VC0 in RC is a protocol error
        cur_x = 2'd2; cur_y = 2'd1; credits = {3'd3, 3'd3, 3'd3, 3'd3};
        head(1'b1, 2'd3, 2'd1, 2'd2);
        step(); hd_valid = 1'b0;
        step();
        chk("vc1_hold_e_valid", route_valid, 2'b10);
        chk("vc1_hold_e_port", route_port[9:5], 5'b00001);
        head(1'b0, 2'd2, 2'd3, 2'd2);
        step(); hd_valid = 1'b0;
        rel_valid = 1'b1; rel_vc = 1'b0;
        step(); rel_valid = 1'b0;
        chk("rel_in_rc_err", err_proto, 1'b1);
        chk("rel_in_rc_still_holds", route_valid, 2'b11);
        chk("vc0_port_n", route_port[4:0], 5'b00100);
        $display("seq rel-in-RC err_proto=%b route_valid=%b", err_proto, route_valid);

        head(1'b1, 2'd0, 2'd0, 2'd2);
        step(); hd_valid = 1'b0;
        chk("head_in_hold_err", err_proto, 1'b1);
        chk("head_in_hold_port", route_port[9:5], 5'b00001);
        step();
        chk("err_proto_pulse_end", err_proto, 1'b0);
        chk("head_in_hold_port_stable", route_port[9:5], 5'b00001);
        $display("seq head-in-HOLD port1=%b", route_port[9:5]);

        rel_valid = 1'b1; rel_vc = 1'b0;
        step(); rel_valid = 1'b0;
        chk("rel_hold_no_err", err_proto, 1'b0);
        step();
        rel_valid = 1'b1; rel_vc = 1'b0;
        step(); rel_valid = 1'b0;
        chk("rel_idle_err", err_proto, 1'b1);
        $display("seq rel-in-IDLE err_proto=%b", err_proto);

        // Same-cycle release and new head on HOLD VC1
        rel_valid = 1'b1; rel_vc = 1'b1;
        head(1'b1, 2'd0, 2'd1, 2'd2);
        step(); rel_valid = 1'b0; hd_valid = 1'b0;
        chk("relhead_no_err", err_proto, 1'b0);
        chk("relhead_in_rc", route_valid[1], 1'b0);
        step();
        chk("relhead_valid", route_valid[1], 1'b1);
        chk("relhead_port_w", route_port[9:5], 5'b00010);
        $display("seq rel+head port1=%b", route_port[9:5]);

        // Asynchronous reset while VC1 is in HOLD
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", route_valid, 2'b00);
        chk("async_reset_port", route_port, 10'd0);
        $display("seq async reset route_valid=%b", route_valid);
        step();
        reset_n = 1'b1;
        step();

        // Out-of-mesh destination on the 3x3 instance; in range for the 4x4 one
        cur_x = 2'd1; cur_y = 2'd1;
        head(1'b0, 2'd3, 2'd0, 2'd1);
        step(); hd_valid = 1'b0;
        chk("dest_err_pulse", b_err_dest, 1'b1);
        chk("dest_ok_4x4", err_dest, 1'b0);
        chk("dest_no_proto", b_err_proto, 1'b0);
        step();
        chk("dest_err_pulse_end", b_err_dest, 1'b0);
        chk("dest_vc_idle", b_route_valid, 2'b00);
        chk("dest_port_zero", b_route_port, 10'd0);
        chk("dest_4x4_routes", route_valid[0], 1'b1);
        chk("dest_4x4_port_e_tie", route_port[4:0], 5'b00001);
        $display("seq err_dest b_err_dest_seen route_valid3=%b", b_route_valid);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
